// File: rtl/mem_line_requester_if.sv
// rtl/mem_line_requester_if.sv - cache-side request channel of the line requester
//
// Groups the signals between the L2 miss/evict logic and mem_line_requester.
//   master : cache side (issues line requests, supplies writeback words,
//            consumes refill words and completion pulses)
//   slave  : requester side (mem_line_requester)
//
// Signals:
//   req_valid / req_ready   line request handshake
//   req_write               1 = writeback, 0 = refill
//   req_addr                line byte address (low offset bits ignored)
//   wb_idx / wb_word        writeback word lookup (combinational in the cache)
//   rd_valid/rd_idx/rd_word refill word return, one-cycle pulse per word
//   done                    one-cycle pulse at line completion
//   err                     one-cycle pulse on timeout abort

interface mem_line_requester_if #(
  parameter int ADDR_W     = 23,
  parameter int DATA_W     = 64,
  parameter int LINE_WORDS = 4
);

  localparam int IDX_W = $clog2(LINE_WORDS);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;

  logic [IDX_W-1:0]  wb_idx;
  logic [DATA_W-1:0] wb_word;

  logic              rd_valid;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_word;

  logic              done;
  logic              err;

  modport master (
    output req_valid,
    output req_write,
    output req_addr,
    output wb_word,
    input  req_ready,
    input  wb_idx,
    input  rd_valid,
    input  rd_idx,
    input  rd_word,
    input  done,
    input  err
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_addr,
    input  wb_word,
    output req_ready,
    output wb_idx,
    output rd_valid,
    output rd_idx,
    output rd_word,
    output done,
    output err
  );

endinterface

// File: rtl/mem_line_requester.sv
// rtl/mem_line_requester.sv - turns one cache-line refill/writeback into per-word memory transactions
//
// Bus-master side of the main-memory interface. One accepted line request
// becomes LINE_WORDS single-word transactions at consecutive 8-byte
// addresses. Refill words are streamed back to the cache as they arrive;
// writeback words are fetched from the cache line buffer via wb_idx.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   defined   : a WAIT-cycle counter aborts the line with an err pulse after
//               TIMEOUT_CYCLES cycles without RDY.
//   undefined : waits for RDY indefinitely; err is tied to 0.
//
// Ports:
//   clk     in     system clock, rising edge
//   rst_n   in     asynchronous active-low reset
//   req_if  slave  cache-side request channel (see mem_line_requester_if)
//   cs      out    memory chip select, high for the whole word transaction
//   ce      out    transaction strobe, one cycle per word
//   rw      out    1 = read, 0 = write
//   addr    out    word byte address
//   data    inout  driven only while ce=1 and rw=0, high-Z otherwise
//   RDY     in     memory completion for the current word

module mem_line_requester #(
  parameter int ADDR_W         = 23,
  parameter int DATA_W         = 64,
  parameter int LINE_WORDS     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_line_requester_if.slave req_if,
  output logic                cs,
  output logic                ce,
  output logic                rw,
  output logic [ADDR_W-1:0]   addr,
  inout  wire  [DATA_W-1:0]   data,
  input  logic                RDY
);

  localparam int IDX_W = $clog2(LINE_WORDS);

  // Byte offset bits inside one line; cleared to align the base address.
  localparam logic [ADDR_W-1:0] LINE_OFF_MASK = ADDR_W'(LINE_WORDS * (DATA_W / 8) - 1);
  localparam logic [ADDR_W-1:0] WORD_BYTES    = ADDR_W'(DATA_W / 8);
  localparam logic [IDX_W-1:0]  LAST_IDX      = IDX_W'(LINE_WORDS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [IDX_W-1:0]  idx;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_valid_q;
  logic [IDX_W-1:0]  rd_idx_q;
  logic [DATA_W-1:0] rd_word_q;
  logic              timeout_hit;
  logic              drive_data;

  // Bus strobes decode straight from the state register so that an
  // asynchronous reset drops cs/ce and releases data immediately.
  assign cs   = (state == S_ISSUE) || (state == S_WAIT);
  assign ce   = (state == S_ISSUE);
  assign rw   = rw_q;
  assign addr = addr_q;

  // rw_q is the inverse of the latched write flag, so a write is rw_q == 0.
  assign drive_data = (state == S_ISSUE) && !rw_q;
  assign data       = drive_data ? req_if.wb_word : {DATA_W{1'bz}};

  assign req_if.req_ready = (state == S_IDLE);
  assign req_if.wb_idx    = idx;
  assign req_if.rd_valid  = rd_valid_q;
  assign req_if.rd_idx    = rd_idx_q;
  assign req_if.rd_word   = rd_word_q;
  assign req_if.done      = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      rw_q       <= 1'b1;
      addr_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_idx_q   <= '0;
      rd_word_q  <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_if.req_valid) begin
            rw_q   <= ~req_if.req_write;
            addr_q <= req_if.req_addr & ~LINE_OFF_MASK;
            idx    <= '0;
            state  <= S_ISSUE;
          end
        end

        // RDY is deliberately not looked at here: the memory only sees the
        // strobe at the end of this cycle.
        S_ISSUE: state <= S_WAIT;

        S_WAIT: begin
          if (RDY) begin
            if (rw_q) begin
              rd_valid_q <= 1'b1;
              rd_idx_q   <= idx;
              rd_word_q  <= data;
            end
            if (idx == LAST_IDX) begin
              state <= S_DONE;
            end else begin
              // Lines are aligned, so this add never carries out of the line.
              idx    <= idx + 1'b1;
              addr_q <= addr_q + WORD_BYTES;
              state  <= S_ISSUE;
            end
          end else if (timeout_hit) begin
            state <= S_IDLE;
          end
        end

        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  // wait_cnt holds the number of WAIT cycles already completed for the
  // current word, so the TIMEOUT_CYCLES-th RDY-less WAIT cycle aborts.
  assign timeout_hit = (state == S_WAIT) && !RDY &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= timeout_hit;
      if (state == S_ISSUE) begin
        wait_cnt <= '0;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  assign req_if.err = err_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout_hit = 1'b0;
  assign req_if.err  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_line_requester.sv
// tb/tb_mem_line_requester.sv - self-checking bench for mem_line_requester

module tb_mem_line_requester;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 64;
  localparam int LW     = 4;
  localparam int TMO    = 8;
  localparam logic [63:0] KEEP = 64'h5A5A_C3C3_A5A5_3C3C;

  logic              clk;
  logic              rst_n;
  logic              cs;
  logic              ce;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  wire  [DATA_W-1:0] data;
  logic              RDY;
  logic [63:0]       mem_drive;
  logic [63:0]       wb_buf [LW];
  logic [63:0]       mem [logic [22:0]];

  int n_cmp;
  int n_fail;

  mem_line_requester_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LW)) rif ();

  mem_line_requester #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_if(rif.slave),
    .cs(cs), .ce(ce), .rw(rw), .addr(addr), .data(data), .RDY(RDY)
  );

  // Memory side: drives the bus whenever the requester must not.
  assign data = (ce && !rw) ? {DATA_W{1'bz}} : mem_drive;
  assign rif.wb_word = wb_buf[rif.wb_idx];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [63:0] mem_rd(input logic [22:0] a);
    if (!mem.exists(a)) mem[a] = {$urandom, $urandom};
    return mem[a];
  endfunction

  // Runs one line from acceptance to done against the reference model:
  // word w lives at base + 8*w; each word is one ce cycle followed by dly
  // wait cycles, RDY given in the last of them.
  task automatic run_line(input bit wr, input logic [22:0] a, input int dly,
                          input bit hold, input bit nwr, input logic [22:0] na,
                          output int done_cyc, output int ce_cnt);
    logic [22:0] base, ea;
    logic [63:0] pword;
    logic [1:0]  pidx;
    bit pend_rd, pend_done, exp_rdv, exp_done, in_wait;
    int w, k, cyc, budget;
    base = a & ~23'h1F;
    @(negedge clk);
    rif.req_valid = 1'b1;
    rif.req_write = wr;
    rif.req_addr  = a;
    RDY = 1'($urandom);
    mem_drive = KEEP;
    n_cmp++;
    if (rif.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL idle_ready: got %b want 1", rif.req_ready);
    end
    @(posedge clk);
    w = 0; k = 0; in_wait = 0; pend_rd = 0; pend_done = 0;
    done_cyc = -1; ce_cnt = 0; cyc = 0; ea = base; pidx = 0; pword = 0;
    budget = (dly + 1) * LW + 8;
    while (done_cyc < 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (hold) begin
        rif.req_write = nwr;
        rif.req_addr  = na;
      end else begin
        rif.req_valid = 1'b0;
      end
      exp_rdv = pend_rd; exp_done = pend_done;
      pend_rd = 0; pend_done = 0;
      n_cmp++;
      if (rif.req_ready !== 1'b0) begin
        n_fail++; $display("FAIL busy_ready: cycle %0d got %b want 0", cyc, rif.req_ready);
      end
      n_cmp++;
      if (rif.rd_valid !== exp_rdv) begin
        n_fail++; $display("FAIL rd_valid: cycle %0d got %b want %b", cyc, rif.rd_valid, exp_rdv);
      end
      if (exp_rdv) begin
        n_cmp++;
        if (rif.rd_idx !== pidx || rif.rd_word !== pword) begin
          n_fail++;
          $display("FAIL rd_word: got idx %0d word %h want idx %0d word %h",
                   rif.rd_idx, rif.rd_word, pidx, pword);
        end
      end
      n_cmp++;
      if (rif.done !== exp_done) begin
        n_fail++; $display("FAIL done: cycle %0d got %b want %b", cyc, rif.done, exp_done);
      end
      n_cmp++;
      if (rif.err !== 1'b0) begin
        n_fail++; $display("FAIL err: cycle %0d got %b want 0", cyc, rif.err);
      end
      if (rif.done === 1'b1) done_cyc = cyc;

      if (w < LW && !in_wait) begin
        ea = base + 23'(8 * w);
        n_cmp++;
        if (cs !== 1'b1 || ce !== 1'b1 || rw !== !wr || addr !== ea) begin
          n_fail++;
          $display("FAIL issue_bus: got cs%b ce%b rw%b addr %h want cs1 ce1 rw%b addr %h",
                   cs, ce, rw, addr, !wr, ea);
        end
        n_cmp++;
        if (wr) begin
          if (data !== wb_buf[w]) begin
            n_fail++; $display("FAIL wr_data: word %0d got %h want %h", w, data, wb_buf[w]);
          end
          mem[ea] = wb_buf[w];
        end else if (data !== mem_drive) begin
          n_fail++; $display("FAIL rd_issue_bus: got %h want %h", data, mem_drive);
        end
        ce_cnt++; in_wait = 1; k = 0;
        RDY = 1'($urandom);
        mem_drive = KEEP;
      end else if (w < LW) begin
        k++;
        n_cmp++;
        if (cs !== 1'b1 || ce !== 1'b0 || rw !== !wr || addr !== ea) begin
          n_fail++;
          $display("FAIL wait_bus: got cs%b ce%b rw%b addr %h want cs1 ce0 rw%b addr %h",
                   cs, ce, rw, addr, !wr, ea);
        end
        n_cmp++;
        if (data !== mem_drive) begin
          n_fail++; $display("FAIL wait_data_release: got %h want %h", data, mem_drive);
        end
        RDY = (k == dly);
        mem_drive = wr ? KEEP : mem_rd(ea);
        if (k == dly) begin
          if (!wr) begin
            pend_rd = 1; pidx = 2'(w); pword = mem_drive;
          end
          if (w == LW - 1) pend_done = 1;
          w++;
          in_wait = 0;
        end
      end else begin
        n_cmp++;
        if (cs !== 1'b0 || ce !== 1'b0) begin
          n_fail++; $display("FAIL done_bus: got cs%b ce%b want cs0 ce0", cs, ce);
        end
        RDY = 1'b0;
        mem_drive = KEEP;
      end
    end
    RDY = 1'b0;
    mem_drive = KEEP;
    n_cmp++;
    if (done_cyc != (dly + 1) * LW + 1) begin
      n_fail++; $display("FAIL line_latency: got %0d want %0d", done_cyc, (dly + 1) * LW + 1);
    end
    n_cmp++;
    if (ce_cnt != LW) begin
      n_fail++; $display("FAIL ce_count: got %0d want %0d", ce_cnt, LW);
    end
  endtask

  task automatic fill_wb_random();
    for (int i = 0; i < LW; i++) wb_buf[i] = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; RDY = 1'b0; mem_drive = KEEP;
    rif.req_valid = 1'b0; rif.req_write = 1'b0; rif.req_addr = '0;
    fill_wb_random();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (cs !== 1'b0 || ce !== 1'b0 || rw !== 1'b1 || addr !== '0) begin
      n_fail++; $display("FAIL reset_bus: got cs%b ce%b rw%b addr %h want cs0 ce0 rw1 addr 0", cs, ce, rw, addr);
    end
    n_cmp++;
    if (data !== KEEP) begin
      n_fail++; $display("FAIL reset_data: got %h want %h", data, KEEP);
    end
    n_cmp++;
    if (rif.req_ready !== 1'b1 || rif.rd_valid !== 1'b0 || rif.done !== 1'b0 || rif.err !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got rdy%b rv%b done%b err%b want 1 0 0 0",
                         rif.req_ready, rif.rd_valid, rif.done, rif.err);
    end
    n_cmp++;
    if (rif.rd_idx !== '0 || rif.rd_word !== '0 || rif.wb_idx !== '0) begin
      n_fail++; $display("FAIL reset_idx: got rd_idx %0d rd_word %h wb_idx %0d want 0 0 0",
                         rif.rd_idx, rif.rd_word, rif.wb_idx);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_refill();
    int dc, cc;
    mem[23'h000000] = 64'h1111_1111_1111_1111;
    mem[23'h000008] = 64'h2222_2222_2222_2222;
    mem[23'h000010] = 64'h3333_3333_3333_3333;
    mem[23'h000018] = 64'h4444_4444_4444_4444;
    run_line(1'b0, 23'h000008, 1, 1'b0, 1'b0, '0, dc, cc);
  endtask

  task automatic test_writeback();
    int dc, cc;
    for (int i = 0; i < LW; i++) wb_buf[i] = 64'h8888_8888_8888_8888 + 64'(i);
    run_line(1'b1, 23'h000020, 1, 1'b0, 1'b0, '0, dc, cc);
    // Reading the same line back returns what the writeback stored.
    run_line(1'b0, 23'h000020, 1, 1'b0, 1'b0, '0, dc, cc);
  endtask

  task automatic test_slow_memory();
    int dc, cc;
    fill_wb_random();
    run_line(1'b1, 23'($urandom), 5, 1'b0, 1'b0, '0, dc, cc);
    run_line(1'b0, 23'($urandom), 5, 1'b0, 1'b0, '0, dc, cc);
  endtask

  task automatic test_top_address();
    int dc, cc;
    fill_wb_random();
    run_line(1'b1, 23'h7FFFE0, 1, 1'b0, 1'b0, '0, dc, cc);
    run_line(1'b0, 23'h7FFFFF, 2, 1'b0, 1'b0, '0, dc, cc);
  endtask

  task automatic test_random_lines();
    int dc, cc;
    for (int n = 0; n < 8; n++) begin
      fill_wb_random();
      run_line(1'($urandom), 23'($urandom), $urandom_range(1, 4), 1'b0, 1'b0, '0, dc, cc);
    end
  endtask

  task automatic test_back_to_back();
    int dc, cc;
    logic [22:0] a2;
    a2 = 23'($urandom);
    fill_wb_random();
    run_line(1'b1, 23'($urandom), 1, 1'b1, 1'b0, a2, dc, cc);
    run_line(1'b0, a2, 1, 1'b0, 1'b0, '0, dc, cc);
  endtask

  task automatic test_reset_mid_line();
    int dc, cc;
    fill_wb_random();
    @(negedge clk);
    rif.req_valid = 1'b1; rif.req_write = 1'b1; rif.req_addr = 23'($urandom);
    @(negedge clk);
    rif.req_valid = 1'b0; RDY = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (cs !== 1'b0 || ce !== 1'b0 || data !== KEEP) begin
      n_fail++; $display("FAIL async_reset: got cs%b ce%b data %h want cs0 ce0 data %h", cs, ce, data, KEEP);
    end
    n_cmp++;
    if (rif.done !== 1'b0 || rif.err !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_pulses: got done%b err%b want 0 0", rif.done, rif.err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rif.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_ready: got %b want 1", rif.req_ready);
    end
    fill_wb_random();
    run_line(1'b1, 23'($urandom), 2, 1'b0, 1'b0, '0, dc, cc);
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int dc, cc;
    @(negedge clk);
    rif.req_valid = 1'b1; rif.req_write = 1'b0; rif.req_addr = 23'($urandom); RDY = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= TMO + 4; c++) begin
      @(negedge clk);
      rif.req_valid = 1'b0; RDY = 1'b0;
      n_cmp++;
      if (rif.err !== (c == TMO + 2) || cs !== (c <= TMO + 1) || rif.done !== 1'b0 || rif.rd_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout: cycle %0d got err%b cs%b done%b rv%b want err%b cs%b done0 rv0",
                 c, rif.err, cs, rif.done, rif.rd_valid, (c == TMO + 2), (c <= TMO + 1));
      end
    end
    run_line(1'b0, 23'($urandom), 1, 1'b0, 1'b0, '0, dc, cc);
  endtask
`else
  task automatic test_stuck_low();
    int dc, cc;
    fill_wb_random();
    run_line(1'b1, 23'($urandom), 40, 1'b0, 1'b0, '0, dc, cc);
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_refill();
    test_writeback();
    test_slow_memory();
    test_top_address();
    test_random_lines();
    test_back_to_back();
    test_reset_mid_line();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`else
    test_stuck_low();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
